// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one byte-oriented I2C master between several clients.
// A watchdog aborts a hung master transaction so no client can hold the bus forever.
module i2c_master_arbiter #(
  parameter int NUM_CLIENTS    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CLIENTS-1:0]   i_c_req,
  input  logic [NUM_CLIENTS-1:0]   i_c_rw,
  input  logic [7*NUM_CLIENTS-1:0] i_c_dev_addr,
  input  logic [8*NUM_CLIENTS-1:0] i_c_reg_addr,
  input  logic [8*NUM_CLIENTS-1:0] i_c_wdata,
  output logic [NUM_CLIENTS-1:0]   o_c_done,
  output logic                     o_c_err,
  output logic [7:0]               o_c_rdata,
  output logic [NUM_CLIENTS-1:0]   o_grant,
  output logic                     o_m_start,
  output logic                     o_m_rw,
  output logic [6:0]               o_m_dev_addr,
  output logic [7:0]               o_m_reg_addr,
  output logic [7:0]               o_m_wdata,
  output logic                     o_m_abort,
  input  logic                     i_m_busy,
  input  logic                     i_m_done,
  input  logic                     i_m_nack,
  input  logic [7:0]               i_m_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLIENTS - 1);

  // state   | meaning
  // IDLE    | pick next requester round-robin, latch its fields
  // ISSUE   | wait for master idle, then pulse start
  // WAIT    | wait for master done, watchdog running
  // RECOVER | abort issued, wait for master to go idle
  // RESPOND | one-cycle done pulse to the granted client
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESPOND, S_RECOVER
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [IW-1:0]          r_rr_ptr, r_gidx;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic [CW-1:0]          r_cnt, w_cnt_inc;
  logic                   r_err, r_m_start, r_m_abort, r_m_rw;
  logic [7:0]             r_rdata, r_m_reg, r_m_wdata;
  logic [6:0]             r_m_dev;
  logic                   w_pick_vld, w_tmo;
  logic [IW-1:0]          w_pick_idx, w_cand;
  logic [NUM_CLIENTS-1:0] w_pick_onehot;
  logic                   w_sel_rw;
  logic [6:0]             w_sel_dev;
  logic [7:0]             w_sel_reg, w_sel_wdata;

  // Scan from the highest offset down so the lowest offset at/after rr_ptr wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      w_cand = IW'((int'(r_rr_ptr) + i) % NUM_CLIENTS);
      if (i_c_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_rw    = 1'b0;
    w_sel_dev   = '0;
    w_sel_reg   = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (w_pick_idx == IW'(k)) begin
        w_sel_rw    = i_c_rw[k];
        w_sel_dev   = i_c_dev_addr[7*k +: 7];
        w_sel_reg   = i_c_reg_addr[8*k +: 8];
        w_sel_wdata = i_c_wdata[8*k +: 8];
      end
    end
  end

  assign w_pick_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_tmo         = (r_cnt == TMO_LAST);
  assign w_cnt_inc     = (r_cnt == TMO_SAT) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pick_vld) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (!i_m_busy)  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_m_done)   w_state_nxt = S_RESPOND;
        else if (w_tmo) w_state_nxt = S_RECOVER;
      end
      S_RECOVER: if (!i_m_busy)  w_state_nxt = S_RESPOND;
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr  <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_m_start <= 1'b0;
      r_m_abort <= 1'b0;
      r_m_rw    <= 1'b0;
      r_m_dev   <= '0;
      r_m_reg   <= '0;
      r_m_wdata <= '0;
    end else begin
      r_m_start <= 1'b0;
      r_m_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_grant   <= w_pick_onehot;
            r_gidx    <= w_pick_idx;
            r_m_rw    <= w_sel_rw;
            r_m_dev   <= w_sel_dev;
            r_m_reg   <= w_sel_reg;
            r_m_wdata <= w_sel_wdata;
            r_cnt     <= '0;
          end
        end
        S_ISSUE: begin
          if (!i_m_busy) begin
            r_m_start <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT: begin
          // A done arriving on the timeout edge takes priority over the abort.
          if (i_m_done) begin
            r_err   <= i_m_nack;
            r_rdata <= (r_m_rw && !i_m_nack) ? i_m_rdata : 8'h00;
          end else if (w_tmo) begin
            r_m_abort <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= 8'h00;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESPOND: begin
          r_rr_ptr <= (r_gidx == LAST_IDX) ? '0 : r_gidx + IW'(1);
          r_grant  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_c_done  = '0;
    o_c_err   = 1'b0;
    o_c_rdata = '0;
    if (r_state == S_RESPOND) begin
      o_c_done  = r_grant;
      o_c_err   = r_err;
      o_c_rdata = r_rdata;
    end
  end

  assign o_grant      = r_grant;
  assign o_m_start    = r_m_start;
  assign o_m_abort    = r_m_abort;
  assign o_m_rw       = r_m_rw;
  assign o_m_dev_addr = r_m_dev;
  assign o_m_reg_addr = r_m_reg;
  assign o_m_wdata    = r_m_wdata;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: a master model answers starts from a response queue,
// a negedge monitor pops expected client results and compares.
module tb_i2c_master_arbiter;
  localparam int NC = 2;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]   c_req, c_rw, c_done, grant;
  logic [7*NC-1:0] c_dev;
  logic [8*NC-1:0] c_reg, c_wdata;
  logic            c_err;
  logic [7:0]      c_rdata;
  logic            m_start, m_rw, m_abort;
  logic [6:0]      m_dev;
  logic [7:0]      m_reg, m_wdata;
  logic            m_busy, m_done, m_nack;
  logic [7:0]      m_rdata;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NUM_CLIENTS(NC), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_rw(c_rw), .i_c_dev_addr(c_dev), .i_c_reg_addr(c_reg),
    .i_c_wdata(c_wdata), .o_c_done(c_done), .o_c_err(c_err), .o_c_rdata(c_rdata),
    .o_grant(grant), .o_m_start(m_start), .o_m_rw(m_rw), .o_m_dev_addr(m_dev),
    .o_m_reg_addr(m_reg), .o_m_wdata(m_wdata), .o_m_abort(m_abort),
    .i_m_busy(m_busy), .i_m_done(m_done), .i_m_nack(m_nack), .i_m_rdata(m_rdata)
  );

  typedef struct {int client; bit err; logic [7:0] rdata; bit abort;} exp_t;
  typedef struct {int lat; bit nack; logic [7:0] rdata; bit hang;} mresp_t;
  exp_t   exp_q[$];
  mresp_t mq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] exp_fields(input int k);
    return (k == 0) ? {1'b1, 7'h50, 8'h02, 8'h00} : {1'b0, 7'h1A, 8'h33, 8'hA5};
  endfunction

  function automatic logic [NC-1:0] onehot(input int k);
    return (k == 0) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Master model: busy from start until done; a hung transaction only ends on abort.
  int   m_cnt, m_hold;
  bit   m_hang, m_cur_nack;
  logic [7:0] m_cur_rd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_nack <= 1'b0; m_rdata <= 8'h00;
      m_cnt <= 0; m_hold <= 0; m_hang <= 1'b0; m_cur_nack <= 1'b0; m_cur_rd <= 8'h00;
    end else begin
      m_done <= 1'b0; m_nack <= 1'b0; m_rdata <= 8'h00;
      if (m_abort) begin
        m_cnt <= 0; m_hang <= 1'b0; m_hold <= 3;
      end else if (m_hold > 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) m_busy <= 1'b0;
      end else if (m_start && mq.size() > 0) begin
        m_busy <= 1'b1; m_cnt <= mq[0].lat; m_hang <= mq[0].hang;
        m_cur_nack <= mq[0].nack; m_cur_rd <= mq[0].rdata;
        mq.delete(0);
      end else if (m_cnt > 0 && !m_hang) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1; m_nack <= m_cur_nack; m_rdata <= m_cur_rd; m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor
  initial begin
    automatic bit done_prev = 1'b0;
    automatic bit abort_seen = 1'b0;
    automatic int start_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_prev) begin
          chk("grant_drop", grant, 0);
          chk("done_one_cycle", c_done, 0);
        end
        done_prev = 1'b0;
        if (m_start) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL start_unexpected: actual start with no pending request");
          end else begin
            chk("start_busy", m_busy, 0);
            chk("start_grant", grant, onehot(exp_q[0].client));
            chk("start_fields", {m_rw, m_dev, m_reg, m_wdata}, exp_fields(exp_q[0].client));
          end
          start_cyc = cyc;
          abort_seen = 1'b0;
        end
        if (m_abort) begin
          abort_seen = 1'b1;
          if (exp_q.size() == 0 || !exp_q[0].abort) begin
            n_checks++; n_errors++;
            $display("FAIL abort_unexpected: actual abort at cycle %0d required none", cyc);
          end else begin
            chk("abort_delay", cyc - start_cyc, TO);
          end
        end
        if (|c_done) begin
          done_prev = 1'b1;
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL done_unexpected: actual done %b required none", c_done);
          end else begin
            e = exp_q.pop_front();
            chk("done_client", c_done, onehot(e.client));
            chk("done_err", c_err, e.err);
            chk("done_rdata", c_rdata, e.rdata);
            chk("done_abort_seen", abort_seen, e.abort);
          end
        end
      end
    end
  end

  task automatic push(input int k, input int lat, input bit nack, input logic [7:0] rd,
                      input bit hang, input bit eerr, input logic [7:0] erd, input bit eab);
    mq.push_back('{lat, nack, rd, hang});
    exp_q.push_back('{k, eerr, erd, eab});
  endtask

  task automatic run(input logic [NC-1:0] mask, input int n);
    int got = 0;
    int waited = 0;
    c_req = mask;
    while (got < n && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (|c_done) begin
        got++;
        if (got == n) c_req = '0;
      end
    end
    c_req = '0;
    chk("run_completions", got, n);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {grant, c_done, c_err, c_rdata, m_start, m_abort, m_rw, m_dev, m_reg, m_wdata}, 0);
  endtask

  initial begin
    c_req   = '0;
    c_rw    = 2'b01;
    c_dev   = {7'h1A, 7'h50};
    c_reg   = {8'h33, 8'h02};
    c_wdata = {8'hA5, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_outputs");
    @(negedge clk) rst_n = 1'b1;

    // single read, client0
    push(0, 50, 1'b0, 8'h0B, 1'b0, 1'b0, 8'h0B, 1'b0);
    run(2'b01, 1);
    // write NACK, client1: rdata forced to 0
    push(1, 20, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0);
    run(2'b10, 1);
    // fairness: both held, order 0,1,0,1
    push(0, 10, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11, 1'b0);
    push(1, 12, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
    push(0,  5, 1'b0, 8'h33, 1'b0, 1'b0, 8'h33, 1'b0);
    push(1,  7, 1'b0, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0);
    run(2'b11, 4);
    // timeout on client0, then client1 served normally
    push(0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    run(2'b01, 1);
    push(1, 15, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0);
    run(2'b10, 1);
    // done sampled on the same edge the watchdog expires
    push(0, TO - 2, 1'b0, 8'h77, 1'b0, 1'b0, 8'h77, 1'b0);
    run(2'b01, 1);

    // reset while client1 waits on a hung master
    push(1, 0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    c_req = 2'b10;
    repeat (30) @(negedge clk);
    chk("grant_in_wait", grant, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_wait");
    exp_q.delete();
    mq.delete();
    c_req = '0;
    @(negedge clk) rst_n = 1'b1;
    push(0, 8, 1'b0, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0);
    push(1, 8, 1'b0, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b0);
    run(2'b11, 2);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
